// File: rtl/endstop_pio_debounced.sv
// endstop_pio_debounced
// Avalon-MM slave that synchronises, debounces and edge-latches WIDTH endstop
// inputs, and raises a maskable level interrupt.
// Optional feature: define ENDSTOPS_POLARITY_EN to get a per-channel polarity
// register at address 3. Without it, POL reads 0 and the level is not inverted.
module endstop_pio_debounced #(
   parameter int WIDTH           = 6,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_MODE       = 0,
   parameter int IDLE_LEVEL      = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_next;
   logic [CW-1:0]    cnt      [WIDTH];
   logic [CW-1:0]    cnt_next [WIDTH];
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] capture_next;
   logic [WIDTH-1:0] polarity;
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] level_next;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] clear_bits;
   logic [31:0]      rd_mux;
   logic             wr;

   assign wr = chipselect & ~write_n;

   generate
      if (WIDTH < 32) begin : g_unused_wdata
         logic unused_wdata;
         assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
      end
   endgenerate

   // Debounce: count consecutive mismatches, accept the new value on the last one
   always_comb begin
      stable_next = stable;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next[i] = '0;
         if (sync2[i] != stable[i]) begin
            if (cnt[i] == CNT_LAST) begin
               stable_next[i] = sync2[i];
            end else begin
               cnt_next[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   // Two-flop synchroniser, accepted level and debounce counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1  <= IDLE_VEC;
         sync2  <= IDLE_VEC;
         stable <= IDLE_VEC;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         sync1  <= in_port;
         sync2  <= sync1;
         stable <= stable_next;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
      end
   end

`ifdef ENDSTOPS_POLARITY_EN
   // Polarity register; a write only changes the view, never creates an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         polarity <= '0;
      end else if (wr && address == 2'd3) begin
         polarity <= writedata[WIDTH-1:0];
      end
   end
`else
   assign polarity = '0;
`endif

   // Edge detection uses the current polarity on both sides of the compare
   always_comb begin
      level      = stable ^ polarity;
      level_next = stable_next ^ polarity;
      rise       = ~level & level_next;
      fall       = level & ~level_next;
      case (EDGE_MODE)
         0:       edge_hit = rise;
         1:       edge_hit = fall;
         default: edge_hit = rise | fall;
      endcase
      clear_bits   = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
      capture_next = (capture & ~clear_bits) | edge_hit;
   end

   // Mask and edge capture registers; a new edge beats a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask    <= '0;
         capture <= '0;
      end else begin
         capture <= capture_next;
         if (wr && address == 2'd1) mask <= writedata[WIDTH-1:0];
      end
   end

   // Zero-extended read mux, sampled every clock
   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux[WIDTH-1:0] = level;
         2'd1:    rd_mux[WIDTH-1:0] = mask;
         2'd2:    rd_mux[WIDTH-1:0] = capture;
         default: rd_mux[WIDTH-1:0] = polarity;
      endcase
   end

   // Registered read data, one clock of latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

   assign irq = |(capture & mask);

endmodule

// File: tb/tb_endstop_pio_debounced.sv
// Self-checking bench for endstop_pio_debounced (WIDTH=6, DEBOUNCE_CYCLES=4).
module tb_endstop_pio_debounced;

   localparam int W = 6;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [W-1:0]  in_port = '0;
   logic [31:0]   readdata;
   logic          irq;

   int vectors = 0;
   int errors  = 0;

   endstop_pio_debounced #(
      .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0), .IDLE_LEVEL(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   // Reference model: a channel accepts a new value once the last D synchronised
   // samples (the raw samples two clocks old and older) all agree and differ.
   logic [W-1:0] m_stable, m_cap, m_mask, m_pol;
   logic [31:0]  m_rd;
   logic [W-1:0] m_hist [0:D+1];
   logic         m_irq;
   assign m_irq = |(m_cap & m_mask);

   task automatic model_reset();
      m_stable = '0; m_cap = '0; m_mask = '0; m_pol = '0; m_rd = '0;
      for (int i = 0; i <= D + 1; i++) m_hist[i] = '0;
   endtask

   task automatic model_step();
      logic [W-1:0] lvl, nstable, nlvl, clr;
      logic         wr, same;
      if (!reset_n) begin
         model_reset();
         return;
      end
      lvl = m_stable ^ m_pol;
      case (address)
         2'd0:    m_rd = 32'(lvl);
         2'd1:    m_rd = 32'(m_mask);
         2'd2:    m_rd = 32'(m_cap);
         default: m_rd = 32'(m_pol);
      endcase
      for (int i = D + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = in_port;
      nstable = m_stable;
      for (int b = 0; b < W; b++) begin
         same = 1'b1;
         for (int j = 3; j <= D + 1; j++) if (m_hist[j][b] != m_hist[2][b]) same = 1'b0;
         if (same && m_hist[2][b] != m_stable[b]) nstable[b] = m_hist[2][b];
      end
      nlvl = nstable ^ m_pol;
      wr   = chipselect && !write_n;
      clr  = (wr && address == 2'd2) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~clr) | (~lvl & nlvl);
      if (wr && address == 2'd1) m_mask = writedata[W-1:0];
`ifdef ENDSTOPS_POLARITY_EN
      if (wr && address == 2'd3) m_pol = writedata[W-1:0];
`endif
      m_stable = nstable;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      vectors++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: readdata=%h irq=%b, expected 00000000 0", readdata, irq);
      end
      in_port = '0;
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         tick();
         vectors++;
         if (readdata !== 32'h0 || irq !== 1'b0 || m_rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_read addr%0d: readdata=%h irq=%b, expected 00000000 0", a, readdata, irq);
         end
      end
   endtask

   task automatic test_debounce();
      address = 2'd0;
      in_port = 6'h01;
      for (int c = 1; c <= 8; c++) begin
         tick();
         vectors++;
         if (readdata !== m_rd || irq !== m_irq) begin
            errors++;
            $display("FAIL debounce_rise cyc%0d: readdata=%h irq=%b, expected %h %b", c, readdata, irq, m_rd, m_irq);
         end
         if ((c == 6 && readdata !== 32'h0) || (c == 7 && readdata !== 32'h1)) begin
            errors++;
            $display("FAIL debounce_latency cyc%0d: readdata=%h, expected %h", c, readdata, (c == 7) ? 1 : 0);
         end
      end
      address = 2'd2;
      tick();
      vectors++;
      if (readdata !== 32'h1) begin
         errors++;
         $display("FAIL edge_rise: readdata=%h, expected 00000001", readdata);
      end
      in_port = 6'h00;
      address = 2'd0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         vectors++;
         if (readdata !== m_rd || irq !== m_irq) begin
            errors++;
            $display("FAIL debounce_fall cyc%0d: readdata=%h irq=%b, expected %h %b", c, readdata, irq, m_rd, m_irq);
         end
      end
      address = 2'd2;
      tick();
      vectors++;
      if (readdata !== 32'h1) begin
         errors++;
         $display("FAIL edge_fall_ignored: readdata=%h, expected 00000001", readdata);
      end
   endtask

   task automatic test_glitch();
      do_write(2'd2, 32'h3F);
      address = 2'd0;
      in_port = 6'h08;
      repeat (3) tick();
      in_port = 6'h00;
      for (int c = 1; c <= 10; c++) begin
         tick();
         vectors++;
         if (readdata !== 32'h0 || readdata !== m_rd) begin
            errors++;
            $display("FAIL glitch_short cyc%0d: readdata=%h, expected 00000000", c, readdata);
         end
      end
      address = 2'd2;
      tick();
      vectors++;
      if (readdata !== 32'h0) begin
         errors++;
         $display("FAIL glitch_short_edge: readdata=%h, expected 00000000", readdata);
      end
      address = 2'd0;
      in_port = 6'h08;
      repeat (6) tick();
      in_port = 6'h00;
      for (int c = 1; c <= 12; c++) begin
         tick();
         vectors++;
         if (readdata !== m_rd || irq !== m_irq) begin
            errors++;
            $display("FAIL glitch_long cyc%0d: readdata=%h irq=%b, expected %h %b", c, readdata, irq, m_rd, m_irq);
         end
      end
      address = 2'd2;
      tick();
      vectors++;
      if (readdata !== 32'h8) begin
         errors++;
         $display("FAIL glitch_long_edge: readdata=%h, expected 00000008", readdata);
      end
   endtask

   task automatic test_irq();
      do_write(2'd2, 32'h3F);
      do_write(2'd1, 32'h01);
      vectors++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_idle: irq=%b, expected 0", irq);
      end
      in_port = 6'h01;
      for (int c = 1; c <= 6; c++) begin
         tick();
         vectors++;
         if (irq !== ((c == 6) ? 1'b1 : 1'b0) || irq !== m_irq) begin
            errors++;
            $display("FAIL irq_assert cyc%0d: irq=%b, expected %b", c, irq, (c == 6));
         end
      end
      do_write(2'd2, 32'h01);
      vectors++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear: irq=%b, expected 0", irq);
      end
      in_port = 6'h00;
      repeat (8) tick();
      in_port = 6'h01;
      repeat (5) tick();
      do_write(2'd2, 32'h01);
      vectors++;
      if (irq !== 1'b1 || irq !== m_irq) begin
         errors++;
         $display("FAIL set_beats_clear_irq: irq=%b, expected 1", irq);
      end
      address = 2'd2;
      tick();
      vectors++;
      if (readdata !== 32'h1) begin
         errors++;
         $display("FAIL set_beats_clear_edge: readdata=%h, expected 00000001", readdata);
      end
   endtask

   task automatic test_polarity();
`ifdef ENDSTOPS_POLARITY_EN
      in_port = 6'h00;
      repeat (8) tick();
      do_write(2'd2, 32'h3F);
      do_write(2'd3, 32'h3F);
      address = 2'd0;
      tick();
      vectors++;
      if (readdata !== 32'h3F) begin
         errors++;
         $display("FAIL pol_data: readdata=%h, expected 0000003f", readdata);
      end
      address = 2'd2;
      tick();
      vectors++;
      if (readdata !== 32'h0) begin
         errors++;
         $display("FAIL pol_no_edge: readdata=%h, expected 00000000", readdata);
      end
      in_port = 6'h20;
      address = 2'd0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         vectors++;
         if (readdata !== m_rd || irq !== m_irq) begin
            errors++;
            $display("FAIL pol_track cyc%0d: readdata=%h irq=%b, expected %h %b", c, readdata, irq, m_rd, m_irq);
         end
      end
      tick();
      vectors++;
      if (readdata !== 32'h1F) begin
         errors++;
         $display("FAIL pol_inv_data: readdata=%h, expected 0000001f", readdata);
      end
      address = 2'd2;
      tick();
      vectors++;
      if (readdata !== 32'h0) begin
         errors++;
         $display("FAIL pol_inv_edge: readdata=%h, expected 00000000", readdata);
      end
      do_write(2'd3, 32'h0);
      in_port = 6'h00;
      repeat (8) tick();
`else
      do_write(2'd3, 32'h3F);
      address = 2'd3;
      tick();
      vectors++;
      if (readdata !== 32'h0) begin
         errors++;
         $display("FAIL pol_absent: readdata=%h, expected 00000000", readdata);
      end
      address = 2'd0;
      tick();
      vectors++;
      if (readdata !== 32'h1) begin
         errors++;
         $display("FAIL pol_absent_data: readdata=%h, expected 00000001", readdata);
      end
      in_port = 6'h00;
      repeat (8) tick();
`endif
   endtask

   task automatic test_reset_mid();
      do_write(2'd2, 32'h3F);
      do_write(2'd1, 32'h3F);
      in_port = 6'h02;
      repeat (8) tick();
      vectors++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre_irq: irq=%b, expected 1", irq);
      end
      address = 2'd1;
      in_port = 6'h03;
      repeat (5) tick();
      reset_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async: readdata=%h irq=%b, expected 00000000 0", readdata, irq);
      end
      @(negedge clk);
      tick();
      reset_n = 1'b1;
      address = 2'd0;
      for (int c = 1; c <= 7; c++) begin
         tick();
         vectors++;
         if (readdata !== m_rd || irq !== m_irq ||
             (c == 6 && readdata !== 32'h0) || (c == 7 && readdata !== 32'h3)) begin
            errors++;
            $display("FAIL midreset_restart cyc%0d: readdata=%h irq=%b, expected %h %b", c, readdata, irq, m_rd, m_irq);
         end
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int c = 0; c < 600; c++) begin
         if (hold == 0) begin
            in_port = W'($urandom);
            hold = $urandom_range(1, 9);
         end
         hold--;
         address    = 2'($urandom);
         chipselect = ($urandom_range(0, 3) == 0);
         write_n    = 1'($urandom);
         writedata  = $urandom;
         tick();
         chipselect = 1'b0;
         write_n    = 1'b1;
         vectors++;
         if (readdata !== m_rd || irq !== m_irq) begin
            errors++;
            $display("FAIL random cyc%0d: readdata=%h irq=%b, expected %h %b", c, readdata, irq, m_rd, m_irq);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_irq();
      test_polarity();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
